mips_multicycle_core: RTL and testbench
=======================================

MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and register width (min 32).
REQ-002 SHALL have parameter REG_COUNT, default 32, number of GPRs (power of 2, 8..32); REG_AW = log2(REG_COUNT).
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after start.
REQ-004 SHALL use one clock; reset is asynchronous and active-low: clk in 1, rising-edge clock; rst in 1, async active-low reset.
REQ-005 start  in  1  one-cycle pulse; begins execution from RESET_PC when idle or halted.
REQ-006 imem_req  out  1  fetch request; imem_addr  out  DATA_W  byte address, word-aligned.
REQ-007 imem_ack  in  1  fetch accept; imem_rdata  in  32  instruction, valid when imem_ack=1.
REQ-008 busy  out  1  high in every state except IDLE and HALT; halted  out  1  high in HALT.
REQ-009 illegal  out  1  sticky; set on an unsupported opcode or funct.
REQ-010 dbg_pc  out  DATA_W  PC of the current instruction; dbg_wr_en  out  1; dbg_wr_reg  out  REG_AW; dbg_wr_data  out  DATA_W  register write trace.
REQ-011 zero  out  1  registered ALU zero flag of the last EXEC.

Function
REQ-012 FSM SHALL have states IDLE, FETCH, DECODE, EXEC, WB and HALT.
- IDLE->FETCH on start.
- FETCH->DECODE on imem_ack.
- DECODE->EXEC always.
- EXEC->WB always.
- WB->FETCH, or WB->HALT on halt or illegal.
- HALT->FETCH on start, with pc reloaded to RESET_PC.
REQ-013 In FETCH, imem_req SHALL stay 1 and imem_addr SHALL stay equal to pc until imem_ack; the instruction SHALL be latched on the ack cycle.
REQ-014 With zero-wait ack, each instruction SHALL take exactly 4 cycles; each ack-wait cycle adds 1.
REQ-015 Supported encodings:
- R-type (op 0x00): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed), 0x00 sll by shamt.
- addi op 0x08, imm sign-extended.
- beq op 0x04.
- j op 0x02.
- halt op 0x3F.
REQ-016 Arithmetic SHALL wrap modulo 2^DATA_W with no overflow trap; slt result SHALL be 1 or 0, zero-extended.
REQ-017 Register-field indices SHALL be truncated to REG_AW bits.
REQ-018 Register 0 SHALL read as 0; a write to it SHALL be discarded, with dbg_wr_en still pulsed.
REQ-019 The register write SHALL occur in WB only for R-type and addi; dbg_wr_* SHALL be valid for exactly that one cycle.
REQ-020 Next pc SHALL be computed in EXEC and committed in WB:
- default pc+4.
- beq taken: pc+4+(sext(imm)<<2).
- j: {pc+4 upper bits, target26, 2'b00}.
REQ-021 beq SHALL compare rs and rt by subtraction; zero SHALL reflect the result of that subtraction.
REQ-022 An illegal instruction SHALL perform no register write, SHALL set illegal, and SHALL cause entry to HALT after WB; pc SHALL hold the illegal instruction's address.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 A start from HALT SHALL clear illegal but SHALL NOT clear the registers.

Reset
REQ-025 On rst=0, the block SHALL immediately enter IDLE and set pc=RESET_PC, all GPRs=0, and imem_req, busy, halted, illegal, dbg_wr_en and zero to 0; dbg_pc, dbg_wr_reg and dbg_wr_data SHALL be 0.
REQ-026 Reset asserted mid-fetch SHALL drop imem_req in the same cycle; a late imem_ack SHALL be ignored in IDLE.

Structure
REQ-027 Package mips_pkg SHALL hold the opcode and funct constants and the FSM state enum.
REQ-028 The ALU SHALL be a sub-module mips_alu, parameterised by DATA_W, with inputs a, b, funct and shamt and outputs result and zero; the regfile SHALL be an internal array.

Verification
REQ-029 Program addi r1,r0,5; addi r2,r0,7; add r3,r1,r2; halt -> dbg_wr_data 5, 7, 12 on regs 1, 2, 3; halted=1 after 16 cycles with zero-wait ack.
REQ-030 sub r4,r1,r2 with r1=5, r2=7 -> 0xFFFFFFFE; slt r5,r1,r2 -> 1; addi r0,r0,9 -> a later read of r0 returns 0.
REQ-031 beq r1,r1,-1 -> dbg_pc repeats the same address each 4 cycles and zero=1; j 0x40 -> next imem_addr 0x100.
REQ-032 imem_ack delayed 3 cycles -> imem_req and imem_addr held stable; the instruction takes 7 cycles.
REQ-033 Op 0x3E fetched -> illegal=1, no dbg_wr_en, halted=1; a start then clears illegal and refetches from RESET_PC.
REQ-034 rst=0 asserted during an ack wait -> all outputs reach their reset values asynchronously; start after release fetches RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct constants and FSM state type for the multicycle MIPS core
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    function automatic logic rtype_funct_ok(input logic [5:0] funct);
        case (funct)
            FN_SLL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: rtype_funct_ok = 1'b1;
            default:                                       rtype_funct_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - combinational ALU selected by R-type funct code
module mips_alu
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (funct)
            FN_ADD:  result = a + b;
            FN_SUB:  result = a - b;
            FN_AND:  result = a & b;
            FN_OR:   result = a | b;
            FN_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            FN_SLL:  result = b << shamt;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multicycle MIPS subset core: fetch, decode, exec, writeback
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                REG_COUNT = 32,
    parameter logic [DATA_W-1:0] RESET_PC  = '0,
    localparam int               REG_AW    = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              busy,
    output logic              halted,
    output logic              illegal,
    output logic [DATA_W-1:0] dbg_pc,
    output logic              dbg_wr_en,
    output logic [REG_AW-1:0] dbg_wr_reg,
    output logic [DATA_W-1:0] dbg_wr_data,
    output logic              zero
);

    state_t state, state_next;

    logic [DATA_W-1:0] pc, pc_next_q, next_pc, pc4;
    logic [DATA_W-1:0] a_q, b_q, alu_b, alu_result;
    logic [DATA_W-1:0] imm_sext, br_target, j_target;
    logic [31:0]       ir;
    logic [5:0]        opcode, funct, alu_funct;
    logic [4:0]        shamt;
    logic [REG_AW-1:0] rs, rt, rd, wr_dest;
    logic              is_rtype, is_addi, is_beq, is_j, is_halt, is_legal;
    logic              writes_reg, alu_zero, stop_q;

    logic [DATA_W-1:0] regs [REG_COUNT];

    assign opcode = ir[31:26];
    assign rs     = ir[21 +: REG_AW];
    assign rt     = ir[16 +: REG_AW];
    assign rd     = ir[11 +: REG_AW];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];

    assign is_rtype   = (opcode == OP_RTYPE) && rtype_funct_ok(funct);
    assign is_addi    = (opcode == OP_ADDI);
    assign is_beq     = (opcode == OP_BEQ);
    assign is_j       = (opcode == OP_J);
    assign is_halt    = (opcode == OP_HALT);
    assign is_legal   = is_rtype || is_addi || is_beq || is_j || is_halt;
    assign writes_reg = is_rtype || is_addi;
    assign wr_dest    = is_addi ? rt : rd;

    assign imm_sext  = {{(DATA_W-16){ir[15]}}, ir[15:0]};
    assign pc4       = pc + DATA_W'(4);
    assign br_target = pc4 + {imm_sext[DATA_W-3:0], 2'b00};
    assign j_target  = {pc4[DATA_W-1:28], ir[25:0], 2'b00};

    // beq reuses the subtract path so the zero flag reflects rs - rt
    assign alu_b     = is_addi ? imm_sext : b_q;
    assign alu_funct = is_rtype ? funct : (is_beq ? FN_SUB : FN_ADD);

    mips_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (a_q),
        .b      (alu_b),
        .funct  (alu_funct),
        .shamt  (shamt),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // An illegal instruction leaves pc pointing at itself
    always_comb begin
        next_pc = pc4;
        if (!is_legal) begin
            next_pc = pc;
        end else if (is_beq && alu_zero) begin
            next_pc = br_target;
        end else if (is_j) begin
            next_pc = j_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_FETCH;
            ST_FETCH:  if (imem_ack) state_next = ST_DECODE;
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC:   state_next = ST_WB;
            ST_WB:     state_next = stop_q ? ST_HALT : ST_FETCH;
            ST_HALT:   if (start) state_next = ST_FETCH;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign busy      = (state != ST_IDLE) && (state != ST_HALT);
    assign halted    = (state == ST_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            pc_next_q   <= '0;
            ir          <= '0;
            a_q         <= '0;
            b_q         <= '0;
            stop_q      <= 1'b0;
            illegal     <= 1'b0;
            zero        <= 1'b0;
            dbg_pc      <= '0;
            dbg_wr_en   <= 1'b0;
            dbg_wr_reg  <= '0;
            dbg_wr_data <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // The write trace lives only for the WB cycle following EXEC
            dbg_wr_en   <= 1'b0;
            dbg_wr_reg  <= '0;
            dbg_wr_data <= '0;
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        pc      <= RESET_PC;
                        illegal <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir     <= imem_rdata;
                        dbg_pc <= pc;
                    end
                end
                ST_DECODE: begin
                    a_q <= regs[rs];
                    b_q <= regs[rt];
                end
                ST_EXEC: begin
                    zero      <= alu_zero;
                    pc_next_q <= next_pc;
                    stop_q    <= is_halt || !is_legal;
                    if (!is_legal) begin
                        illegal <= 1'b1;
                    end
                    if (writes_reg) begin
                        dbg_wr_en   <= 1'b1;
                        dbg_wr_reg  <= wr_dest;
                        dbg_wr_data <= alu_result;
                    end
                end
                ST_WB: begin
                    pc <= pc_next_q;
                    if (dbg_wr_en && (dbg_wr_reg != '0)) begin
                        regs[dbg_wr_reg] <= dbg_wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - self-checking bench with instruction memory model and write scoreboard
module tb_mips_multicycle_core;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        busy, halted, illegal, dbg_wr_en, zero;
    logic [31:0] dbg_pc, dbg_wr_data;
    logic [4:0]  dbg_wr_reg;

    mips_multicycle_core #(
        .DATA_W    (32),
        .REG_COUNT (32),
        .RESET_PC  (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .dbg_pc      (dbg_pc),
        .dbg_wr_en   (dbg_wr_en),
        .dbg_wr_reg  (dbg_wr_reg),
        .dbg_wr_data (dbg_wr_data),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        zf;
    } wr_t;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } fetch_t;

    typedef struct {
        logic [31:0] instr;
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ack_wait = 0;
    int          wait_cnt = 0;
    logic        stray_ack = 1'b0;
    logic [31:0] held_addr = '0;
    logic [31:0] imem [128];
    wr_t         sb [$];
    fetch_t      flog [$];
    wr_t         e;
    vec_t        tbl [18];
    int          n;

    localparam logic [31:0] HALT_I = {OP_HALT, 26'h0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh,
                                          input logic [5:0] fn);
        enc_r = {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        enc_i = {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic expect_wr(input int rd, input logic [31:0] data);
        sb.push_back('{5'(rd), data, (data == 32'h0)});
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 128; i++) imem[i] = HALT_I;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halted(input int limit, output int cnt);
        cnt = 0;
        while (!halted && cnt < limit) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model and write monitor, both evaluated away from the rising edge
    always @(negedge clk) begin
        if (imem_req) begin
            if (wait_cnt == 0) begin
                held_addr = imem_addr;
                flog.push_back('{imem_addr, cyc});
            end else begin
                check("fetch_addr_stable", imem_addr, held_addr);
            end
            imem_ack   = stray_ack || (wait_cnt == ack_wait);
            imem_rdata = imem[imem_addr[8:2]];
            wait_cnt++;
        end else begin
            wait_cnt   = 0;
            imem_ack   = stray_ack;
            imem_rdata = 32'h0;
        end
        if (dbg_wr_en) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: reg %0d data 0x%0h with nothing expected", dbg_wr_reg, dbg_wr_data);
            end else begin
                e = sb.pop_front();
                check("wr_reg", dbg_wr_reg, e.rd);
                check("wr_data", dbg_wr_data, e.data);
                check("wr_zero", zero, e.zf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{enc_i(OP_ADDI, 0, 1, 5),        1'b1, 5'd1,  32'd5};
        tbl[1]  = '{enc_i(OP_ADDI, 0, 2, 7),        1'b1, 5'd2,  32'd7};
        tbl[2]  = '{enc_r(1, 2, 4, 0, FN_SUB),      1'b1, 5'd4,  32'hFFFF_FFFE};
        tbl[3]  = '{enc_r(1, 2, 5, 0, FN_SLT),      1'b1, 5'd5,  32'd1};
        tbl[4]  = '{enc_r(2, 1, 6, 0, FN_SLT),      1'b1, 5'd6,  32'd0};
        tbl[5]  = '{enc_r(1, 2, 7, 0, FN_AND),      1'b1, 5'd7,  32'd5};
        tbl[6]  = '{enc_r(1, 2, 8, 0, FN_OR),       1'b1, 5'd8,  32'd7};
        tbl[7]  = '{enc_r(0, 2, 9, 4, FN_SLL),      1'b1, 5'd9,  32'h70};
        tbl[8]  = '{enc_i(OP_ADDI, 0, 0, 9),        1'b1, 5'd0,  32'd9};
        tbl[9]  = '{enc_r(0, 0, 10, 0, FN_ADD),     1'b1, 5'd10, 32'd0};
        tbl[10] = '{enc_i(OP_ADDI, 0, 11, -1),      1'b1, 5'd11, 32'hFFFF_FFFF};
        tbl[11] = '{enc_i(OP_ADDI, 11, 12, 1),      1'b1, 5'd12, 32'd0};
        tbl[12] = '{enc_r(11, 1, 13, 0, FN_SLT),    1'b1, 5'd13, 32'd1};
        tbl[13] = '{enc_r(11, 11, 14, 0, FN_ADD),   1'b1, 5'd14, 32'hFFFF_FFFE};
        tbl[14] = '{enc_i(OP_BEQ, 1, 2, 1),         1'b0, 5'd0,  32'd0};
        tbl[15] = '{enc_i(OP_BEQ, 1, 1, 1),         1'b0, 5'd0,  32'd0};
        tbl[16] = '{enc_i(OP_ADDI, 0, 15, 99),      1'b0, 5'd0,  32'd0};
        tbl[17] = '{enc_r(0, 1, 16, 0, FN_SUB),     1'b1, 5'd16, 32'hFFFF_FFFB};

        clear_imem();
        #12;
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_dbg_wr_en", dbg_wr_en, 1'b0);
        check("rst_zero", zero, 1'b0);
        check("rst_dbg_pc", dbg_pc, 32'h0);
        check("rst_dbg_wr_reg", dbg_wr_reg, 5'h0);
        check("rst_dbg_wr_data", dbg_wr_data, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Basic four-instruction program with zero-wait fetch
        imem[0] = enc_i(OP_ADDI, 0, 1, 5);
        imem[1] = enc_i(OP_ADDI, 0, 2, 7);
        imem[2] = enc_r(1, 2, 3, 0, FN_ADD);
        expect_wr(1, 32'd5);
        expect_wr(2, 32'd7);
        expect_wr(3, 32'd12);
        flog.delete();
        do_start();
        check("prog1_busy", busy, 1'b1);
        wait_halted(100, n);
        check("prog1_cycles", n, 16);
        check("prog1_halted", halted, 1'b1);
        check("prog1_first_fetch", (flog.size() > 0) ? flog[0].addr : 32'hFFFF_FFFF, 32'h0);
        check("prog1_sb_drained", sb.size(), 0);

        // Table of vectors run as one program from HALT
        clear_imem();
        for (int i = 0; i < 18; i++) begin
            imem[i] = tbl[i].instr;
            if (tbl[i].wr) expect_wr(tbl[i].rd, tbl[i].data);
        end
        do_start();
        wait_halted(400, n);
        check("tbl_cycles", n, 72);
        check("tbl_dbg_pc", dbg_pc, 32'd72);
        check("tbl_sb_drained", sb.size(), 0);

        // Register retention across start, then illegal opcode
        clear_imem();
        imem[0] = enc_r(1, 0, 2, 0, FN_ADD);
        imem[1] = {6'h3E, 26'h0};
        expect_wr(2, 32'd5);
        do_start();
        wait_halted(100, n);
        check("ill_cycles", n, 8);
        check("ill_flag", illegal, 1'b1);
        check("ill_halted", halted, 1'b1);
        check("ill_dbg_pc", dbg_pc, 32'h4);
        check("ill_pc_held", imem_addr, 32'h4);
        check("ill_sb_drained", sb.size(), 0);
        imem[1] = HALT_I;
        expect_wr(2, 32'd5);
        do_start();
        check("ill_cleared", illegal, 1'b0);
        check("ill_refetch_addr", imem_addr, 32'h0);
        check("ill_refetch_req", imem_req, 1'b1);
        wait_halted(100, n);
        check("ill_after_restart", illegal, 1'b0);

        // Jump target formation
        clear_imem();
        imem[0] = {OP_J, 26'h40};
        flog.delete();
        do_start();
        wait_halted(100, n);
        check("j_cycles", n, 8);
        check("j_target", (flog.size() > 1) ? flog[1].addr : 32'hFFFF_FFFF, 32'h100);

        // Fetch with three ack-wait cycles
        clear_imem();
        imem[0] = enc_i(OP_ADDI, 0, 3, 3);
        expect_wr(3, 32'd3);
        ack_wait = 3;
        do_start();
        check("wait_req_held", imem_req, 1'b1);
        wait_halted(200, n);
        check("wait_cycles", n, 14);
        ack_wait = 0;

        // Self-branching beq loops on its own address
        clear_imem();
        imem[0] = enc_i(OP_ADDI, 0, 1, 5);
        imem[1] = enc_i(OP_BEQ, 1, 1, -1);
        expect_wr(1, 32'd5);
        flog.delete();
        do_start();
        repeat (20) @(negedge clk);
        check("beq_fetch_count", flog.size() >= 4, 1'b1);
        if (flog.size() >= 4) begin
            check("beq_addr1", flog[1].addr, 32'h4);
            check("beq_addr3", flog[3].addr, 32'h4);
            check("beq_period", flog[3].cyc - flog[2].cyc, 4);
        end
        check("beq_dbg_pc", dbg_pc, 32'h4);
        check("beq_zero", zero, 1'b1);
        check("beq_still_busy", busy, 1'b1);
        check("beq_sb_drained", sb.size(), 0);

        // Reset in the middle of an ack wait
        ack_wait = 50;
        @(negedge clk);
        while (!imem_req) @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_imem_req", imem_req, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_halted", halted, 1'b0);
        check("arst_zero", zero, 1'b0);
        check("arst_dbg_pc", dbg_pc, 32'h0);
        check("arst_imem_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        ack_wait = 0;
        #2;
        stray_ack = 1'b1;
        imem_ack = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        stray_ack = 1'b0;
        imem_ack = 1'b0;
        check("late_ack_idle_busy", busy, 1'b0);
        check("late_ack_idle_halted", halted, 1'b0);
        clear_imem();
        flog.delete();
        do_start();
        check("arst_restart_addr", imem_addr, 32'h0);
        wait_halted(100, n);
        check("arst_restart_cycles", n, 4);
        check("arst_first_fetch", (flog.size() > 0) ? flog[0].addr : 32'hFFFF_FFFF, 32'h0);
        check("final_sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
